layer_sequencer: RTL and testbench



---
 rtl/layer_sequencer_if.sv | 41 ++++
 rtl/layer_sequencer.sv | 142 ++++++++++++++
 tb/tb_layer_sequencer.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/layer_sequencer_if.sv
// Bundle between the network input buffer / result consumer / `layer` datapath and the sequencer.
// master = surrounding system, slave = layer_sequencer.
interface layer_sequencer_if #(
  parameter int NUM_NEURON  = 6,
  parameter int NUM_INPUTS  = 5,
  parameter int INPUT_SIZE  = 9,
  parameter int OUTPUT_SIZE = 10,
  parameter int LAYER_BITS  = 2
);
  logic                              cfg_we;
  logic [LAYER_BITS-1:0]             cfg_addr;
  logic [NUM_NEURON-1:0]             cfg_active;
  logic [LAYER_BITS:0]               num_layers;
  logic                              in_valid;
  logic                              in_ready;
  logic [NUM_INPUTS*INPUT_SIZE-1:0]  in_data;
  logic                              layer_start;
  logic [NUM_NEURON-1:0]             layer_active;
  logic [NUM_INPUTS*INPUT_SIZE-1:0]  layer_inputs;
  logic [LAYER_BITS-1:0]             layer_idx;
  logic [NUM_NEURON*OUTPUT_SIZE-1:0] layer_out_values;
  logic [NUM_NEURON-1:0]             layer_out_valid;
  logic                              out_valid;
  logic                              out_ready;
  logic [NUM_NEURON*OUTPUT_SIZE-1:0] out_data;
  logic                              error;

  modport master (
    output cfg_we, cfg_addr, cfg_active, num_layers, in_valid, in_data,
           layer_out_values, layer_out_valid, out_ready,
    input  in_ready, layer_start, layer_active, layer_inputs, layer_idx,
           out_valid, out_data, error
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_active, num_layers, in_valid, in_data,
           layer_out_values, layer_out_valid, out_ready,
    output in_ready, layer_start, layer_active, layer_inputs, layer_idx,
           out_valid, out_data, error
  );
endinterface

// File: rtl/layer_sequencer.sv
// Time-multiplexes one physical `layer` datapath over up to MAX_LAYERS logical layers,
// feeding saturated outputs back as the next layer's inputs.
module layer_sequencer #(
  parameter int NUM_NEURON  = 6,
  parameter int NUM_INPUTS  = 5,
  parameter int INPUT_SIZE  = 9,
  parameter int OUTPUT_SIZE = 10,
  parameter int MAX_LAYERS  = 4,
  parameter int LAYER_BITS  = 2,
  parameter int TIMEOUT     = 255,
  parameter int TIMER_BITS  = 8
) (
  input logic              clk,
  input logic              rst,
  layer_sequencer_if.slave bus
);

  // state   | meaning
  // IDLE    | in_ready, config writes, accept input    START | layer_start pulse
  // ARM     | skip stale layer valid    WAIT | watchdog    CAPTURE | latch/feed back    DONE | out_valid
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_ARM     = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [TIMER_BITS-1:0] WDOG_LOAD = TIMER_BITS'(TIMEOUT - 1);
  localparam int SAT_MAX_I = 2 ** (INPUT_SIZE - 1) - 1;
  localparam logic signed [OUTPUT_SIZE-1:0] SAT_MAX = OUTPUT_SIZE'(SAT_MAX_I);
  localparam logic signed [OUTPUT_SIZE-1:0] SAT_MIN = OUTPUT_SIZE'(-SAT_MAX_I - 1);

  logic [2:0]                        state;
  logic [NUM_NEURON-1:0]             cfg_table [MAX_LAYERS];
  logic [NUM_NEURON-1:0]             mask_reg;
  logic [NUM_INPUTS*INPUT_SIZE-1:0]  inputs_reg;
  logic [LAYER_BITS-1:0]             idx_reg;
  logic [LAYER_BITS-1:0]             next_idx;
  logic [LAYER_BITS:0]               layers_reg;
  logic [LAYER_BITS:0]               layers_clamped;
  logic [NUM_NEURON*OUTPUT_SIZE-1:0] result_reg;
  logic [NUM_NEURON*OUTPUT_SIZE-1:0] masked;
  logic [TIMER_BITS-1:0]             wdog;
  logic                              error_reg;
  logic                              done;
  logic                              last;

  function automatic logic [INPUT_SIZE-1:0] sat(input logic signed [OUTPUT_SIZE-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[INPUT_SIZE-1:0];
    else if (v < SAT_MIN) return SAT_MIN[INPUT_SIZE-1:0];
    else                  return v[INPUT_SIZE-1:0];
  endfunction

  always_comb begin
    layers_clamped = bus.num_layers;
    if (bus.num_layers == '0)
      layers_clamped = (LAYER_BITS+1)'(1);
    else if (int'(bus.num_layers) > MAX_LAYERS)
      layers_clamped = (LAYER_BITS+1)'(MAX_LAYERS);
  end

  always_comb begin
    masked = '0;
    for (int i = 0; i < NUM_NEURON; i++)
      if (mask_reg[i])
        masked[i*OUTPUT_SIZE +: OUTPUT_SIZE] = bus.layer_out_values[i*OUTPUT_SIZE +: OUTPUT_SIZE];
  end

  assign done     = ((bus.layer_out_valid & mask_reg) == mask_reg);
  assign last     = ({1'b0, idx_reg} == (layers_reg - (LAYER_BITS+1)'(1)));
  assign next_idx = idx_reg + LAYER_BITS'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      mask_reg   <= '0;
      inputs_reg <= '0;
      idx_reg    <= '0;
      layers_reg <= '0;
      result_reg <= '0;
      wdog       <= '0;
      error_reg  <= 1'b0;
      for (int i = 0; i < MAX_LAYERS; i++)
        cfg_table[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.cfg_we && (int'(bus.cfg_addr) < MAX_LAYERS))
            cfg_table[bus.cfg_addr] <= bus.cfg_active;
          if (bus.in_valid) begin
            inputs_reg <= bus.in_data;
            layers_reg <= layers_clamped;
            idx_reg    <= '0;
            error_reg  <= 1'b0;
            mask_reg   <= cfg_table[0];
            state      <= S_START;
          end
        end
        S_START: begin
          wdog  <= WDOG_LOAD;
          state <= S_ARM;
        end
        S_ARM: state <= S_WAIT;
        S_WAIT: begin
          if (done) begin
            result_reg <= masked;
            state      <= S_CAPTURE;
          end else if (wdog == '0) begin
            error_reg <= 1'b1;
            state     <= S_IDLE;
          end else begin
            wdog <= wdog - TIMER_BITS'(1);
          end
        end
        S_CAPTURE: begin
          if (last) begin
            state <= S_DONE;
          end else begin
            // Only the first NUM_INPUTS neurons feed the next layer.
            for (int i = 0; i < NUM_INPUTS; i++)
              inputs_reg[i*INPUT_SIZE +: INPUT_SIZE] <= sat(result_reg[i*OUTPUT_SIZE +: OUTPUT_SIZE]);
            idx_reg  <= next_idx;
            mask_reg <= cfg_table[next_idx];
            state    <= S_START;
          end
        end
        S_DONE: if (bus.out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready     = (state == S_IDLE);
  assign bus.layer_start  = (state == S_START);
  assign bus.layer_active = mask_reg;
  assign bus.layer_inputs = inputs_reg;
  assign bus.layer_idx    = idx_reg;
  assign bus.out_valid    = (state == S_DONE);
  assign bus.out_data     = result_reg;
  assign bus.error        = error_reg;

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: a behavioural `layer` model checks each start,
// a monitor checks each result handshake against hand-computed expectations.
module tb_layer_sequencer;
  localparam int NN = 6;
  localparam int NI = 5;
  localparam int IS = 9;
  localparam int OS = 10;

  typedef struct {
    logic [1:0]       idx;
    logic [NN-1:0]    active;
    logic [NI*IS-1:0] inputs;
    int               off;
  } start_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   acc_cyc = 0;
  int   ov_rise_cyc = 0;

  start_t           exp_start[$];
  logic [NN*OS-1:0] exp_out[$];
  logic [NN*OS-1:0] model_vals [4];
  int               model_lat = 5;
  bit               model_never = 0;

  layer_sequencer_if #(.NUM_NEURON(NN), .NUM_INPUTS(NI), .INPUT_SIZE(IS),
                       .OUTPUT_SIZE(OS), .LAYER_BITS(2)) bus ();

  layer_sequencer #(.NUM_NEURON(NN), .NUM_INPUTS(NI), .INPUT_SIZE(IS), .OUTPUT_SIZE(OS),
                    .MAX_LAYERS(4), .LAYER_BITS(2), .TIMEOUT(255), .TIMER_BITS(8)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation still running at 300000 ns, required finish");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [NI*IS-1:0] pk_in(input int a0, input int a1, input int a2,
                                             input int a3, input int a4);
    logic [NI*IS-1:0] r;
    r = {9'(a4), 9'(a3), 9'(a2), 9'(a1), 9'(a0)};
    return r;
  endfunction

  function automatic logic [NN*OS-1:0] pk_out(input int n0, input int n1, input int n2,
                                              input int n3, input int n4, input int n5);
    logic [NN*OS-1:0] r;
    r = {10'(n5), 10'(n4), 10'(n3), 10'(n2), 10'(n1), 10'(n0)};
    return r;
  endfunction

  function automatic logic [NN*OS-1:0] all_out(input int v);
    return pk_out(v, v, v, v, v, v);
  endfunction

  task automatic push_start(input int idx, input logic [NN-1:0] m, input logic [NI*IS-1:0] din,
                            input int off);
    start_t s;
    s.idx    = 2'(idx);
    s.active = m;
    s.inputs = din;
    s.off    = off;
    exp_start.push_back(s);
  endtask

  // Behavioural `layer`: clears valid on start, raises all valids model_lat cycles later.
  initial begin
    start_t s;
    int cnt;
    int cur;
    cnt = 0;
    cur = 0;
    bus.layer_out_valid  = '0;
    bus.layer_out_values = '0;
    forever begin
      @(negedge clk);
      if (bus.layer_start) begin
        if (exp_start.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL start_unexpected: got layer_start idx=%0d, expected no start", bus.layer_idx);
        end else begin
          s = exp_start.pop_front();
          chk("start_idx", 64'(bus.layer_idx), 64'(s.idx));
          chk("start_mask", 64'(bus.layer_active), 64'(s.active));
          chk("start_inputs", 64'(bus.layer_inputs), 64'(s.inputs));
          if (s.off >= 0) chk("start_cycle", cyc - acc_cyc, s.off);
        end
        cur = int'(bus.layer_idx);
        bus.layer_out_valid = '0;
        cnt = model_lat;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0 && !model_never) begin
          bus.layer_out_values = model_vals[cur];
          bus.layer_out_valid  = '1;
        end
      end
    end
  end

  initial begin
    logic [NN*OS-1:0] e;
    bit ov_prev;
    ov_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.out_valid && !ov_prev) ov_rise_cyc = cyc;
      ov_prev = bus.out_valid;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_out.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL out_unexpected: got out_data 0x%0h, expected no output", bus.out_data);
        end else begin
          e = exp_out.pop_front();
          chk("out_data", 64'(bus.out_data), 64'(e));
        end
      end
    end
  end

  task automatic cfg(input int addr, input logic [NN-1:0] m);
    @(posedge clk); #1;
    bus.cfg_we     = 1'b1;
    bus.cfg_addr   = 2'(addr);
    bus.cfg_active = m;
    @(posedge clk); #1;
    bus.cfg_we     = 1'b0;
  endtask

  task automatic start_pass(input logic [2:0] nl, input logic [NI*IS-1:0] din);
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    bus.num_layers = nl;
    bus.in_data    = din;
    bus.in_valid   = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL accept: in_ready=0 for 20 cycles, required 1");
    end
    acc_cyc = cyc;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_idle: in_ready=0 after 600 cycles, required 1", name);
    end
  endtask

  task automatic run_pass(input string name, input logic [2:0] nl, input logic [NI*IS-1:0] din);
    start_pass(nl, din);
    wait_idle(name);
  endtask

  initial begin
    bit ok;
    int err_cyc;
    rst_n          = 1'b0;
    bus.cfg_we     = 1'b0;
    bus.cfg_addr   = '0;
    bus.cfg_active = '0;
    bus.num_layers = '0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b1;
    for (int i = 0; i < 4; i++) model_vals[i] = '0;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 1);
    chk("rst_layer_start", 64'(bus.layer_start), 0);
    chk("rst_layer_active", 64'(bus.layer_active), 0);
    chk("rst_layer_inputs", 64'(bus.layer_inputs), 0);
    chk("rst_layer_idx", 64'(bus.layer_idx), 0);
    chk("rst_out_valid", 64'(bus.out_valid), 0);
    chk("rst_out_data", 64'(bus.out_data), 0);
    chk("rst_error", 64'(bus.error), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // single layer, 5-cycle layer latency
    cfg(0, 6'b000001);
    model_vals[0] = pk_out(100, 77, 77, 77, 77, 77);
    model_lat = 5;
    push_start(0, 6'b000001, pk_in(-40, 43, 103, 7, -150), 1);
    exp_out.push_back(pk_out(100, 0, 0, 0, 0, 0));
    run_pass("t1", 3'd1, pk_in(-40, 43, 103, 7, -150));
    chk("t1_out_valid_cycle", ov_rise_cyc - acc_cyc, 8);

    // three layers, saturation of 300 to 255 on feedback
    cfg(0, 6'b000011);
    cfg(1, 6'b011111);
    cfg(2, 6'b111111);
    for (int i = 0; i < 3; i++) model_vals[i] = all_out(300);
    push_start(0, 6'b000011, pk_in(1, 2, 3, 4, 5), 1);
    push_start(1, 6'b011111, pk_in(255, 255, 0, 0, 0), 8);
    push_start(2, 6'b111111, pk_in(255, 255, 255, 255, 255), 15);
    exp_out.push_back(all_out(300));
    run_pass("t2", 3'd3, pk_in(1, 2, 3, 4, 5));

    // negative saturation and pass-through, minimum latency
    cfg(1, 6'b111111);
    model_vals[0] = pk_out(-300, 200, 9, 9, 9, 9);
    model_vals[1] = pk_out(-512, 511, -257, 256, 255, -256);
    model_lat = 2;
    push_start(0, 6'b000011, pk_in(0, -1, 2, -3, 4), 1);
    push_start(1, 6'b111111, pk_in(-256, 200, 0, 0, 0), 5);
    exp_out.push_back(pk_out(-512, 511, -257, 256, 255, -256));
    run_pass("t3", 3'd2, pk_in(0, -1, 2, -3, 4));

    // zero mask layer completes in first WAIT cycle with zero outputs
    cfg(0, 6'b000000);
    cfg(1, 6'b000111);
    model_vals[0] = all_out(50);
    model_vals[1] = pk_out(10, -20, 30, 40, 50, 60);
    model_lat = 5;
    push_start(0, 6'b000000, pk_in(7, 7, 7, 7, 7), 1);
    push_start(1, 6'b000111, pk_in(0, 0, 0, 0, 0), 5);
    exp_out.push_back(pk_out(10, -20, 30, 0, 0, 0));
    run_pass("t4", 3'd2, pk_in(7, 7, 7, 7, 7));

    // num_layers=7 clamps to 4
    cfg(0, 6'b100000);
    cfg(1, 6'b000001);
    cfg(2, 6'b000010);
    cfg(3, 6'b000100);
    model_vals[0] = all_out(40);
    model_vals[1] = all_out(11);
    model_vals[2] = all_out(12);
    model_vals[3] = all_out(13);
    model_lat = 2;
    push_start(0, 6'b100000, pk_in(5, 6, 7, 8, 9), 1);
    push_start(1, 6'b000001, pk_in(0, 0, 0, 0, 0), 5);
    push_start(2, 6'b000010, pk_in(11, 0, 0, 0, 0), 9);
    push_start(3, 6'b000100, pk_in(0, 12, 0, 0, 0), 13);
    exp_out.push_back(pk_out(0, 0, 13, 0, 0, 0));
    run_pass("t5", 3'd7, pk_in(5, 6, 7, 8, 9));

    // watchdog timeout
    model_never = 1;
    push_start(0, 6'b100000, pk_in(1, 1, 1, 1, 1), 1);
    start_pass(3'd1, pk_in(1, 1, 1, 1, 1));
    ok = 0;
    err_cyc = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (bus.error) begin ok = 1; err_cyc = cyc; break; end
    end
    chk("t6_error_seen", 64'(ok), 1);
    chk("t6_error_cycle", err_cyc - acc_cyc, 258);
    chk("t6_in_ready", 64'(bus.in_ready), 1);
    chk("t6_out_valid", 64'(bus.out_valid), 0);
    model_never = 0;

    // num_layers=0 treated as 1; accepted input clears error
    model_vals[0] = all_out(40);
    model_lat = 3;
    push_start(0, 6'b100000, pk_in(2, 2, 2, 2, 2), 1);
    exp_out.push_back(pk_out(0, 0, 0, 0, 0, 40));
    start_pass(3'd0, pk_in(2, 2, 2, 2, 2));
    @(negedge clk);
    chk("t7_error_cleared", 64'(bus.error), 0);
    wait_idle("t7");

    // consumer stalls in DONE; config write there must be ignored
    bus.out_ready = 1'b0;
    model_vals[0] = all_out(-5);
    model_lat = 2;
    push_start(0, 6'b100000, pk_in(3, 3, 3, 3, 3), 1);
    exp_out.push_back(pk_out(0, 0, 0, 0, 0, -5));
    start_pass(3'd1, pk_in(3, 3, 3, 3, 3));
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.out_valid) begin ok = 1; break; end
    end
    chk("t8_out_valid_seen", 64'(ok), 1);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      bus.cfg_we     = (k == 2);
      bus.cfg_addr   = 2'd0;
      bus.cfg_active = 6'b111111;
      @(negedge clk);
      chk("t8_hold_data", 64'(bus.out_data), 64'(pk_out(0, 0, 0, 0, 0, -5)));
      chk("t8_hold_in_ready", 64'(bus.in_ready), 0);
      chk("t8_hold_out_valid", 64'(bus.out_valid), 1);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t8_post_out_valid", 64'(bus.out_valid), 0);
    chk("t8_post_in_ready", 64'(bus.in_ready), 1);

    model_vals[0] = all_out(1);
    push_start(0, 6'b100000, pk_in(4, 4, 4, 4, 4), 1);
    exp_out.push_back(pk_out(0, 0, 0, 0, 0, 1));
    run_pass("t9", 3'd1, pk_in(4, 4, 4, 4, 4));

    // async reset mid-pass clears everything including the table
    model_lat = 5;
    push_start(0, 6'b100000, pk_in(5, 5, 5, 5, 5), 1);
    start_pass(3'd1, pk_in(5, 5, 5, 5, 5));
    @(posedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("t10_rst_in_ready", 64'(bus.in_ready), 1);
    chk("t10_rst_layer_active", 64'(bus.layer_active), 0);
    chk("t10_rst_layer_inputs", 64'(bus.layer_inputs), 0);
    chk("t10_rst_out_valid", 64'(bus.out_valid), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_start(0, 6'b000000, pk_in(6, 6, 6, 6, 6), 1);
    exp_out.push_back(all_out(0));
    run_pass("t10", 3'd1, pk_in(6, 6, 6, 6, 6));

    repeat (3) @(negedge clk);
    chk("start_queue_empty", 64'(exp_start.size()), 0);
    chk("out_queue_empty", 64'(exp_out.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
